// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing source with pixel enable, blanking, sync and coordinates
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   run         1 = generate timing, 0 = hold in reset state (synchronous)
//   pix_ce      one-clk pulse in the first cycle of each pixel
//   hblank      horizontal blanking
//   vblank      vertical blanking
//   hs, vs      sync outputs, active level HS_ACT / VS_ACT
//   de          data enable (!hblank && !vblank)
//   hcount      current pixel x
//   vcount      current line y
//   line_start  hcount == 0
//   frame_start hcount == 0 && vcount == 0
module video_timing_gen #(
    parameter int   CE_DIV   = 4,
    parameter int   H_ACTIVE = 256,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 16,
    parameter int   V_ACTIVE = 224,
    parameter int   V_FP     = 8,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 27,
    parameter logic HS_ACT   = 1'b0,
    parameter logic VS_ACT   = 1'b0,
    parameter int   HCNT_W   = 11,
    parameter int   VCNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic              pix_ce,
    output logic              hblank,
    output logic              vblank,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              line_start,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_BLANK  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_BLANK  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [HCNT_W-1:0] h_next;
    logic [VCNT_W-1:0] v_next;
    logic              hb_next;
    logic              vb_next;
    logic              hs_on;
    logic              vs_on;

    assign tick = (div_cnt == DIV_LAST);

    // Next raster position; every registered output is decoded from it so the
    // whole set moves together on the tick edge.
    always_comb begin
        h_next = hcount + HCNT_W'(1);
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + VCNT_W'(1);
        end
    end

    assign hb_next = (h_next >= H_BLANK);
    assign vb_next = (v_next >= V_BLANK);
    assign hs_on   = (h_next >= HS_START) && (h_next < HS_END);
    assign vs_on   = (v_next >= VS_START) && (v_next < VS_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            pix_ce      <= 1'b0;
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hs          <= ~HS_ACT;
            vs          <= ~VS_ACT;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!run) begin
            div_cnt     <= '0;
            pix_ce      <= 1'b0;
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hs          <= ~HS_ACT;
            vs          <= ~VS_ACT;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_ce  <= tick;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                hcount      <= h_next;
                vcount      <= v_next;
                hblank      <= hb_next;
                vblank      <= vb_next;
                hs          <= hs_on ? HS_ACT : ~HS_ACT;
                de          <= !hb_next && !vb_next;
                line_start  <= (h_next == '0);
                frame_start <= (h_next == '0) && (v_next == '0);
                // vertical sync edges are aligned to the start of a line
                if (h_next == '0) begin
                    vs <= vs_on ? VS_ACT : ~VS_ACT;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed, table-driven bench for video_timing_gen
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        run;
    logic        run1;

    logic        pix_ce, hblank, vblank, hs, vs, de, line_start, frame_start;
    logic [10:0] hcount;
    logic [9:0]  vcount;

    logic        pix_ce_1, hblank_1, vblank_1, hs_1, vs_1, de_1, line_start_1, frame_start_1;
    logic [10:0] hcount_1;
    logic [9:0]  vcount_1;

    video_timing_gen #(
        .CE_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_ACT(1'b0), .VS_ACT(1'b0), .HCNT_W(11), .VCNT_W(10)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .run(run),
        .pix_ce(pix_ce), .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs), .de(de),
        .hcount(hcount), .vcount(vcount), .line_start(line_start), .frame_start(frame_start)
    );

    video_timing_gen #(
        .CE_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_ACT(1'b0), .VS_ACT(1'b0), .HCNT_W(11), .VCNT_W(10)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .run(run1),
        .pix_ce(pix_ce_1), .hblank(hblank_1), .vblank(vblank_1), .hs(hs_1), .vs(vs_1), .de(de_1),
        .hcount(hcount_1), .vcount(vcount_1), .line_start(line_start_1), .frame_start(frame_start_1)
    );

    typedef struct {
        int   h;
        int   v;
        logic hb, vb, hsx, vsx, dex, ls, fs;
    } vec_t;

    vec_t       vecs [15];
    logic [6:0] cap [0:7][0:15];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " pix_ce"}, 32'(pix_ce), 0);
        chk({tag, " hcount"}, 32'(hcount), 15);
        chk({tag, " vcount"}, 32'(vcount), 7);
        chk({tag, " hblank"}, 32'(hblank), 1);
        chk({tag, " vblank"}, 32'(vblank), 1);
        chk({tag, " hs"}, 32'(hs), 1);
        chk({tag, " vs"}, 32'(vs), 1);
        chk({tag, " de"}, 32'(de), 0);
        chk({tag, " line_start"}, 32'(line_start), 0);
        chk({tag, " frame_start"}, 32'(frame_start), 0);
    endtask

    // Decode expected straight from the bench geometry: H 8/2/3/3, V 4/1/2/1.
    task automatic check_pos(input string tag, input int h, input int v);
        logic ehb, evb;
        ehb = (h >= 8);
        evb = (v >= 4);
        chk($sformatf("%s hcount", tag), 32'(hcount), 32'(h));
        chk($sformatf("%s vcount", tag), 32'(vcount), 32'(v));
        chk($sformatf("%s hblank", tag), 32'(hblank), 32'(ehb));
        chk($sformatf("%s vblank", tag), 32'(vblank), 32'(evb));
        chk($sformatf("%s hs", tag), 32'(hs), (h >= 10 && h < 13) ? 0 : 1);
        chk($sformatf("%s vs", tag), 32'(vs), (v >= 5 && v < 7) ? 0 : 1);
        chk($sformatf("%s de", tag), 32'(de), 32'(!ehb && !evb));
        chk($sformatf("%s line_start", tag), 32'(line_start), 32'(h == 0));
        chk($sformatf("%s frame_start", tag), 32'(frame_start), 32'(h == 0 && v == 0));
    endtask

    // After reset/run release: three quiet clocks, then the (0,0) tick.
    task automatic check_restart(input string tag);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) chk($sformatf("%s quiet clk%0d pix_ce", tag, i), 32'(pix_ce), 0);
        end
        chk({tag, " first pix_ce"}, 32'(pix_ce), 1);
        check_pos({tag, " first tick"}, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pulses, fs_cnt, ls_cnt, k, last_h;
        bit  found;

        vecs[0]  = '{0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{7,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{9,  1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{10, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{12, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{13, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3,  2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{15, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{0,  4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{15, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{0,  5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{15, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{0,  7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{11, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        run     = 1'b0;
        run1    = 1'b0;
        repeat (3) step();
        check_reset_state("por");
        chk("por ce1 pix_ce", 32'(pix_ce_1), 0);
        chk("por ce1 hcount", 32'(hcount_1), 15);

        @(negedge clk) reset_n = 1'b1;
        step();
        check_reset_state("run_low");

        // full frame plus the wrap tick
        @(negedge clk) run = 1'b1;
        pulses = 0; fs_cnt = 0; ls_cnt = 0; last_h = -1;
        for (int cyc = 1; cyc <= 516; cyc++) begin
            step();
            chk($sformatf("cyc%0d pix_ce", cyc), 32'(pix_ce), 32'(cyc % 4 == 0));
            if (pix_ce) begin
                k = cyc / 4 - 1;
                if (k < 128) begin
                    pulses++;
                    if (frame_start) fs_cnt++;
                    if (line_start) ls_cnt++;
                    cap[k / 16][k % 16] = {hblank, vblank, hs, vs, de, line_start, frame_start};
                    check_pos($sformatf("tick%0d", k), k % 16, k / 16);
                end else begin
                    check_pos("frame_wrap", 0, 0);
                end
                last_h = int'(hcount);
            end else if (last_h >= 0) begin
                chk($sformatf("cyc%0d hold hcount", cyc), 32'(hcount), 32'(last_h));
            end
        end
        chk("pulses per frame", 32'(pulses), 128);
        chk("frame_start per frame", 32'(fs_cnt), 1);
        chk("line_start per frame", 32'(ls_cnt), 8);

        for (int i = 0; i < 15; i++) begin
            logic [6:0] c;
            c = cap[vecs[i].v][vecs[i].h];
            chk($sformatf("vec%0d hblank", i), 32'(c[6]), 32'(vecs[i].hb));
            chk($sformatf("vec%0d vblank", i), 32'(c[5]), 32'(vecs[i].vb));
            chk($sformatf("vec%0d hs", i), 32'(c[4]), 32'(vecs[i].hsx));
            chk($sformatf("vec%0d vs", i), 32'(c[3]), 32'(vecs[i].vsx));
            chk($sformatf("vec%0d de", i), 32'(c[2]), 32'(vecs[i].dex));
            chk($sformatf("vec%0d line_start", i), 32'(c[1]), 32'(vecs[i].ls));
            chk($sformatf("vec%0d frame_start", i), 32'(c[0]), 32'(vecs[i].fs));
        end

        // run dropped at (5,2)
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (pix_ce && hcount == 11'd5 && vcount == 10'd2) found = 1'b1;
        end
        chk("reach (5,2)", 32'(found), 1);
        @(negedge clk) run = 1'b0;
        step();
        check_reset_state("run_drop");
        @(negedge clk) run = 1'b1;
        check_restart("run_rise");

        // asynchronous reset mid-line, between clock edges
        repeat (23) step();
        chk("pre_async not reset", 32'(hcount == 11'd15 && vcount == 10'd7), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk) reset_n = 1'b1;
        check_restart("async_recover");

        // CE_DIV=1 instance
        @(negedge clk) run1 = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            chk($sformatf("ce1 clk%0d pix_ce", j), 32'(pix_ce_1), 1);
            chk($sformatf("ce1 clk%0d hcount", j), 32'(hcount_1), 32'(j % 16));
            chk($sformatf("ce1 clk%0d vcount", j), 32'(vcount_1), 32'(j / 16));
            chk($sformatf("ce1 clk%0d de", j), 32'(de_1), 32'((j % 16) < 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing source that produces the pixel clock enable, blanking, sync, data-enable and pixel coordinates consumed by the horizontal blending filter and the video output chain. It is the upstream end of that video interface. All outputs are registered and change only together on pixel ticks, so any downstream stage sampling on pix_ce sees a consistent set. Frame geometry is fixed by parameters.

Parameters:
CE_DIV, 4, clk cycles per pixel (>=1)
H_ACTIVE, 256, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 32, horizontal sync width (pixels)
H_BP, 16, horizontal back porch (pixels, >=1)
V_ACTIVE, 224, visible lines
V_FP, 8, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BP, 27, vertical back porch (lines, >=1)
HS_ACT, 0, active level of hs
VS_ACT, 0, active level of vs
HCNT_W, 11, hcount width
VCNT_W, 10, vcount width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = generate timing; 0 = hold in reset state (synchronous)
pix_ce  out  1  pixel enable pulse
hblank  out  1  horizontal blanking
vblank  out  1  vertical blanking
hs  out  1  horizontal sync (polarity HS_ACT)
vs  out  1  vertical sync (polarity VS_ACT)
de  out  1  !hblank && !vblank
hcount  out  HCNT_W  current pixel x
vcount  out  VCNT_W  current line y
line_start  out  1  hcount==0
frame_start  out  1  hcount==0 && vcount==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider div_cnt counts 0..CE_DIV-1 while run=1. A tick occurs on the clk edge where div_cnt==CE_DIV-1; div_cnt then wraps to 0. With CE_DIV=1, every cycle is a tick.
- On a tick, the position advances and all outputs except pix_ce are reloaded from the new position on that same edge. pix_ce is registered high for exactly the one clk cycle following a tick edge, and is 0 otherwise. Each output set is therefore held for CE_DIV cycles, and pix_ce is high during the first of those cycles.
- Position advance: hcount = H_TOTAL-1 wraps to 0 and increments vcount; otherwise hcount+1. vcount = V_TOTAL-1 wraps to 0.
- Decode, for position (h,v):
  - hblank = h >= H_ACTIVE
  - hs active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vblank = v >= V_ACTIVE
  - vs active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vs changes only when h=0.
- Reset state (reset_n=0, async), also the state after any clk with run=0:
  - div_cnt=0, pix_ce=0
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1
  - hblank=1, vblank=1, de=0
  - hs=!HS_ACT, vs=!VS_ACT
  - line_start=0, frame_start=0
- After release (run=1), the first tick lands on (0,0): frame_start=1, line_start=1, de=1 (given H_ACTIVE, V_ACTIVE >= 1). That first tick edge is CE_DIV clk edges after release.
- run dropped mid-frame: the next clk edge forces the reset state; there is no partial-line completion. Re-raising run restarts at frame (0,0).
- reset_n asserted mid-operation: all outputs take reset values immediately (asynchronously).
- Counter widths must hold H_TOTAL-1 and V_TOTAL-1. Out-of-range parameters are unsupported, and the bench does not exercise them.

Test Plan:
- Bench parameters: CE_DIV=4; H 8/2/3/3 (H_TOTAL=16); V 4/1/2/1 (V_TOTAL=8); HS_ACT=VS_ACT=0.
- Reset then run=1 -> pix_ce pulses every 4th clk, each one cycle wide. The first pulse is at clk 4 after release, with hcount=0, vcount=0, frame_start=1, de=1, hs=1.
- One full line -> hblank=1 for hcount 8..15; hs=0 for hcount 10..12; line_start=1 only at hcount 0; 16 pix_ce pulses per line.
- One full frame -> vblank=1 for vcount 4..7; vs=0 for vcount 5..6, switching at hcount=0; 128 pix_ce pulses per frame; frame_start exactly once per frame.
- run=0 at hcount=5, vcount=2 -> next clk gives the reset state (hcount=15, vcount=7, hblank=1, vblank=1, pix_ce=0). run=1 again -> the next tick lands on (0,0) with frame_start=1.
- reset_n pulsed low asynchronously mid-line -> outputs go to reset values without a clk edge. Recovery matches the first scenario.
- CE_DIV=1 rebuild -> pix_ce high every clk after release; hcount increments every clk; wrap 15->0 increments vcount.
